branch_resolve_unit: RTL and testbench

- Consumer end of the ALU flag interface.
- Holds the architectural NZVC flag register, updated from ALU flag outputs on flag-setting instructions.
- Evaluates B, B.cond, CBZ and CBNZ against current or bypassed flags.
- Drives a handshaked PC redirect to fetch, then a squash window for wrong-path instructions in the pipeline.

---
 rtl/branch_resolve_unit_if.sv | 37 +++
 rtl/branch_resolve_unit.sv | 113 +++++++++++
 tb/tb_branch_resolve_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Bundle between the branch resolve unit and its neighbours: ALU flags, the
// branch request, the fetch redirect handshake and the status outputs.
interface branch_resolve_unit_if #(
   parameter int ADDR_W = 64,
   parameter int CNT_W  = 16
);
   logic              ex_valid;
   logic              ex_set_flags;
   logic              alu_negative;
   logic              alu_zero;
   logic              alu_overflow;
   logic              alu_carry_out;
   logic              br_valid;
   logic              br_ready;
   logic [1:0]        br_type;
   logic [3:0]        br_cond;
   logic              br_reg_zero;
   logic [ADDR_W-1:0] br_target;
   logic              redirect_valid;
   logic              redirect_ready;
   logic [ADDR_W-1:0] redirect_pc;
   logic              squash;
   logic [3:0]        flags_q;
   logic [CNT_W-1:0]  taken_count;

   modport master (
      output ex_valid, ex_set_flags, alu_negative, alu_zero, alu_overflow, alu_carry_out,
      output br_valid, br_type, br_cond, br_reg_zero, br_target, redirect_ready,
      input  br_ready, redirect_valid, redirect_pc, squash, flags_q, taken_count
   );

   modport slave (
      input  ex_valid, ex_set_flags, alu_negative, alu_zero, alu_overflow, alu_carry_out,
      input  br_valid, br_type, br_cond, br_reg_zero, br_target, redirect_ready,
      output br_ready, redirect_valid, redirect_pc, squash, flags_q, taken_count
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Holds NZVC, resolves B / B.cond / CBZ / CBNZ, then issues a handshaked fetch
// redirect followed by a fixed-length squash window.
module branch_resolve_unit #(
   parameter int ADDR_W = 64,
   parameter int SHADOW = 2,
   parameter int CNT_W  = 16
) (
   input logic                 clk,
   input logic                 reset,
   branch_resolve_unit_if.slave bus
);
   localparam int SW = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);

   typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_e;

   state_e            state_q, state_d;
   logic [3:0]        flags_q;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  tcnt_q, tcnt_d;
   logic [SW-1:0]     scnt_q, scnt_d;
   logic              flag_wr;
   logic [3:0]        alu_flags, eff_flags;
   logic              taken, br_ready;

   // Odd codes invert the even predicate, except 1111 which stays "always".
   function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
      logic n, z, v, cy, r;
      {n, z, v, cy} = f;
      case (c[3:1])
         3'd0:    r = z;
         3'd1:    r = cy;
         3'd2:    r = n;
         3'd3:    r = v;
         3'd4:    r = cy & ~z;
         3'd5:    r = (n == v);
         3'd6:    r = ~z & (n == v);
         default: r = 1'b1;
      endcase
      if (c[0] && c[3:1] != 3'd7) r = ~r;
      return r;
   endfunction

   assign flag_wr   = bus.ex_valid & bus.ex_set_flags;
   assign alu_flags = {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry_out};
   assign eff_flags = flag_wr ? alu_flags : flags_q;

   always_comb begin
      taken = 1'b0;
      case (bus.br_type)
         2'b00: taken = 1'b1;
         2'b01: taken = cond_true(bus.br_cond, eff_flags);
         2'b10: taken = bus.br_reg_zero;
         2'b11: taken = ~bus.br_reg_zero;
         default: taken = 1'b0;
      endcase
   end

   assign br_ready = (state_q == IDLE) && !reset;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tcnt_d  = tcnt_q;
      scnt_d  = scnt_q;
      case (state_q)
         IDLE: begin
            if (bus.br_valid && br_ready && taken) begin
               pc_d    = bus.br_target;
               state_d = REDIRECT;
               if (tcnt_q != '1) tcnt_d = tcnt_q + CNT_W'(1);
            end
         end
         REDIRECT: begin
            if (bus.redirect_ready) begin
               if (SHADOW == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = SQUASH;
                  scnt_d  = SW'(SHADOW);
               end
            end
         end
         SQUASH: begin
            scnt_d = scnt_q - SW'(1);
            if (scnt_q == SW'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         flags_q <= '0;
         pc_q    <= '0;
         tcnt_q  <= '0;
         scnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tcnt_q  <= tcnt_d;
         scnt_q  <= scnt_d;
         if (flag_wr) flags_q <= alu_flags;
      end
   end

   assign bus.br_ready       = br_ready;
   assign bus.redirect_valid = (state_q == REDIRECT);
   assign bus.redirect_pc    = pc_q;
   assign bus.squash         = (state_q == SQUASH);
   assign bus.flags_q        = flags_q;
   assign bus.taken_count    = tcnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; the taken counter is narrowed so
// saturation is reachable in a short run.
module tb_branch_resolve_unit;
   localparam int ADDR_W = 64;
   localparam int SHADOW = 2;
   localparam int CNT_W  = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   exp_cnt = 0;

   always #5 clk = ~clk;

   branch_resolve_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   branch_resolve_unit #(.ADDR_W(ADDR_W), .SHADOW(SHADOW), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_flags(input logic n, input logic z, input logic v, input logic c);
      bus.ex_valid = 1'b1; bus.ex_set_flags = 1'b1;
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry_out} = {n, z, v, c};
      @(negedge clk);
      bus.ex_valid = 1'b0; bus.ex_set_flags = 1'b0;
      chk("flags_latch", 64'(bus.flags_q), 64'({n, z, v, c}));
   endtask

   // Issues one branch from IDLE; if taken, walks the redirect and squash phases.
   task automatic do_br(input string tag, input logic [1:0] ty, input logic [3:0] cond,
                        input logic rz, input logic [63:0] tgt, input logic exp_taken);
      chk({tag, "_rdy"}, 64'(bus.br_ready), 64'd1);
      bus.br_valid = 1'b1; bus.br_type = ty; bus.br_cond = cond;
      bus.br_reg_zero = rz; bus.br_target = tgt;
      @(negedge clk);
      bus.br_valid = 1'b0;
      if (exp_taken && exp_cnt < 7) exp_cnt++;
      chk({tag, "_rv"}, 64'(bus.redirect_valid), 64'(exp_taken));
      chk({tag, "_cnt"}, 64'(bus.taken_count), 64'(exp_cnt));
      if (exp_taken) begin
         chk({tag, "_pc"}, bus.redirect_pc, tgt);
         bus.redirect_ready = 1'b1;
         @(negedge clk);
         bus.redirect_ready = 1'b0;
         chk({tag, "_sq1"}, 64'(bus.squash), 64'd1);
         @(negedge clk);
         chk({tag, "_sq2"}, 64'(bus.squash), 64'd1);
         @(negedge clk);
         chk({tag, "_sq_end"}, 64'(bus.squash), 64'd0);
      end
      chk({tag, "_rdy_after"}, 64'(bus.br_ready), 64'd1);
   endtask

   initial begin
      bus.ex_valid = 1'b0; bus.ex_set_flags = 1'b0;
      bus.alu_negative = 1'b0; bus.alu_zero = 1'b0;
      bus.alu_overflow = 1'b0; bus.alu_carry_out = 1'b0;
      bus.br_valid = 1'b0; bus.br_type = 2'b00; bus.br_cond = 4'h0;
      bus.br_reg_zero = 1'b0; bus.br_target = '0; bus.redirect_ready = 1'b0;

      #12;
      chk("rst_rv", 64'(bus.redirect_valid), 64'd0);
      chk("rst_sq", 64'(bus.squash), 64'd0);
      chk("rst_flags", 64'(bus.flags_q), 64'd0);
      chk("rst_cnt", 64'(bus.taken_count), 64'd0);
      chk("rst_pc", bus.redirect_pc, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("rst_rdy", 64'(bus.br_ready), 64'd1);
      @(negedge clk);

      // SUBS result N=0 Z=1 V=0 C=1, then B.EQ taken
      set_flags(1'b0, 1'b1, 1'b0, 1'b1);
      do_br("beq", 2'b01, 4'b0000, 1'b0, 64'h40, 1'b1);

      // Same-cycle flag write clears Z, so EQ must see the bypassed value
      bus.ex_valid = 1'b1; bus.ex_set_flags = 1'b1;
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry_out} = 4'b0000;
      bus.br_valid = 1'b1; bus.br_type = 2'b01; bus.br_cond = 4'b0000; bus.br_target = 64'h80;
      @(negedge clk);
      bus.ex_valid = 1'b0; bus.ex_set_flags = 1'b0; bus.br_valid = 1'b0;
      chk("byp_rv", 64'(bus.redirect_valid), 64'd0);
      chk("byp_rdy", 64'(bus.br_ready), 64'd1);
      chk("byp_flags", 64'(bus.flags_q), 64'd0);
      chk("byp_cnt", 64'(bus.taken_count), 64'd1);

      // Redirect backpressure with a competing request held on br_valid
      bus.br_valid = 1'b1; bus.br_type = 2'b00; bus.br_target = 64'h100;
      @(negedge clk);
      exp_cnt = 2;
      bus.br_target = 64'h200;
      for (int i = 0; i < 3; i++) begin
         chk("bp_rv", 64'(bus.redirect_valid), 64'd1);
         chk("bp_pc", bus.redirect_pc, 64'h100);
         chk("bp_rdy", 64'(bus.br_ready), 64'd0);
         @(negedge clk);
      end
      bus.br_valid = 1'b0;
      bus.redirect_ready = 1'b1;
      @(negedge clk);
      bus.redirect_ready = 1'b0;
      chk("bp_sq1", 64'(bus.squash), 64'd1);
      chk("bp_rv_off", 64'(bus.redirect_valid), 64'd0);
      @(negedge clk);
      chk("bp_sq2", 64'(bus.squash), 64'd1);
      @(negedge clk);
      chk("bp_sq_end", 64'(bus.squash), 64'd0);
      chk("bp_rdy_back", 64'(bus.br_ready), 64'd1);
      chk("bp_cnt", 64'(bus.taken_count), 64'd2);

      set_flags(1'b1, 1'b0, 1'b0, 1'b0);
      do_br("lt", 2'b01, 4'b1011, 1'b0, 64'h1000, 1'b1);
      do_br("ge", 2'b01, 4'b1010, 1'b0, 64'h1004, 1'b0);
      set_flags(1'b1, 1'b0, 1'b1, 1'b0);
      do_br("gt", 2'b01, 4'b1100, 1'b0, 64'h1008, 1'b1);
      set_flags(1'b0, 1'b1, 1'b0, 1'b1);
      do_br("hi", 2'b01, 4'b1000, 1'b0, 64'h100c, 1'b0);
      do_br("ls", 2'b01, 4'b1001, 1'b0, 64'h1010, 1'b1);
      do_br("nv", 2'b01, 4'b1111, 1'b0, 64'h1014, 1'b1);
      do_br("cbz", 2'b10, 4'b0001, 1'b1, 64'h2000, 1'b1);
      do_br("cbnz", 2'b11, 4'b0000, 1'b1, 64'h2004, 1'b0);
      do_br("sat", 2'b00, 4'b0001, 1'b0, 64'hdead_beef_0000_0010, 1'b1);
      chk("sat_cnt", 64'(bus.taken_count), 64'd7);

      // Reset in the middle of the squash window
      bus.br_valid = 1'b1; bus.br_type = 2'b00; bus.br_target = 64'h3000;
      @(negedge clk);
      bus.br_valid = 1'b0;
      bus.redirect_ready = 1'b1;
      @(negedge clk);
      bus.redirect_ready = 1'b0;
      @(negedge clk);
      chk("mid_sq2", 64'(bus.squash), 64'd1);
      reset = 1'b1;
      #1;
      chk("async_sq", 64'(bus.squash), 64'd0);
      chk("async_rv", 64'(bus.redirect_valid), 64'd0);
      chk("async_flags", 64'(bus.flags_q), 64'd0);
      chk("async_cnt", 64'(bus.taken_count), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("post_rv", 64'(bus.redirect_valid), 64'd0);
      chk("post_rdy", 64'(bus.br_ready), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
